// File: rtl/alu_req_driver.sv
// Request buffer + sequencer that drives a multi-cycle ALU one operation at a time
// and returns each result, in request order, over a valid/ready response port.
module alu_req_driver #(
  parameter int WIDTH       = 8,
  parameter int LATENCY     = 1,
  parameter int MUL_LATENCY = 2,
  parameter int DEPTH       = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_mode,
  input  logic [3:0]           req_cmd,
  input  logic [1:0]           req_inp_valid,
  input  logic [WIDTH-1:0]     req_opa,
  input  logic [WIDTH-1:0]     req_opb,
  input  logic                 req_cin,
  input  logic [3:0]           req_tag,
  output logic [1:0]           INP_VALID,
  output logic                 MODE,
  output logic [3:0]           CMD,
  output logic                 CE,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic                 CIN,
  input  logic [2*WIDTH-1:0]   RES,
  input  logic                 ERR,
  input  logic                 OFLOW,
  input  logic                 COUT,
  input  logic                 G,
  input  logic                 L,
  input  logic                 E,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_tag,
  output logic [2*WIDTH-1:0]   rsp_res,
  output logic [5:0]           rsp_flags,
  output logic [15:0]          ops_done,
  output logic [7:0]           err_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int MAXLAT = (LATENCY > MUL_LATENCY) ? LATENCY : MUL_LATENCY;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic             mode;
    logic [3:0]       cmd;
    logic [1:0]       iv;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [3:0]       tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             req_entry;
  entry_t             op_q, op_d;
  state_t             state_q, state_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         rsp_tag_q, rsp_tag_d;
  logic [2*WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic [5:0]         rsp_flags_q, rsp_flags_d;
  logic [15:0]        ops_q, ops_d;
  logic [7:0]         errc_q, errc_d;
  logic               empty, full, push, pop, is_mul, active;

  assign req_entry = '{mode: req_mode, cmd: req_cmd, iv: req_inp_valid, opa: req_opa,
                       opb: req_opb, cin: req_cin, tag: req_tag};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign is_mul    = op_q.mode && ((op_q.cmd == 4'd9) || (op_q.cmd == 4'd10));
  assign active    = (state_q == S_ISSUE) || (state_q == S_WAIT);

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem_q[wr_ptr_q[AW-1:0]] <= req_entry;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    ops_d       = ops_q;
    errc_d      = errc_q;
    pop         = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = is_mul ? MUL_LOAD : LAT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_tag_d   = op_q.tag;
          rsp_res_d   = RES;
          rsp_flags_d = {ERR, OFLOW, COUT, G, L, E};
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (rsp_ready) begin
          ops_d = ops_q + 16'd1;
          if (rsp_flags_q[5] && (errc_q != 8'hFF)) begin
            errc_d = errc_q + 8'd1;
          end
          // Chain straight into the next issue when work is already queued.
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      op_d     = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      rsp_tag_q   <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      ops_q       <= '0;
      errc_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
      ops_q       <= ops_d;
      errc_q      <= errc_d;
    end
  end

  // Operands stay on the bus between operations; only CE and INP_VALID drop.
  assign CE        = active;
  assign INP_VALID = active ? op_q.iv : 2'b00;
  assign MODE      = op_q.mode;
  assign CMD       = op_q.cmd;
  assign OPA       = op_q.opa;
  assign OPB       = op_q.opb;
  assign CIN       = op_q.cin;

  assign rsp_valid = (state_q == S_HOLD);
  assign rsp_tag   = rsp_tag_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;
  assign ops_done  = ops_q;
  assign err_count = errc_q;

endmodule
